uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Shares one 8N1 UART transmitter among NREQ byte sources using round-robin arbitration.
- Contains its own 16x-oversampled baud tick divisor, derived from F/(16*B), and the TX frame sequencer.
- Sits between on-chip byte producers (debug, status, console) and the board TX pin.

Parameters:
- NREQ, 4, number of requesters (2..8).
- B, 9600, baud rate.
- F, 50000000, clk frequency in Hz.
- DIV_W, 16, tick-divisor counter width; must hold F/(16*B).

Ports:
- clk  in  1  system clock
- reset  in  1  reset; asynchronous, active-high
- req  in  NREQ  per-requester send request, level; held until gnt
- din  in  8*NREQ  byte for requester i at din[8*i+7:8*i]; stable while req[i] high
- gnt  out  NREQ  one-hot, one-cycle pulse; din of that requester latched this edge
- owner  out  clog2(NREQ)  index of current/last granted requester
- busy  out  1  high from grant cycle through last stop-bit cycle
- tx  out  1  serial line, idle high

Behaviour:
- Reset values (async, immediate):
  - tx=1, gnt=0, busy=0, owner=0.
  - state=IDLE, all counters 0.
  - Round-robin pointer = NREQ-1, so requester 0 has first priority.
- Divisor:
  - DIV = F/(16*B), integer truncation. Defaults give DIV=325.
  - Tick counter runs 0..DIV-1; tick is asserted when it equals DIV-1, then it wraps to 0.
  - Phase counter runs 0..15 and advances on tick.
  - One bit lasts exactly 16*DIV clk cycles (defaults: 5200).
  - Both counters clear on grant, so every frame is aligned to its start bit.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if req!=0, on the next edge:
    - select the first set req[i], searching from pointer+1 upward with wrap modulo NREQ;
    - gnt[i]=1, owner=i, pointer=i;
    - load shift register with din[i];
    - busy=1, tx=0, state=START.
    - If req==0: tx=1 and busy=0.
  - START: tx=0 for one bit period, then state=DATA, bit index=0, tx=shift[0].
  - DATA: LSB first. Each bit-period end shifts right and increments the index. After bit 7 period ends: state=STOP, tx=1.
  - STOP: tx=1 for one bit period. At its end: state=IDLE, busy=0.
- gnt is high for exactly one cycle per frame. Its cycle coincides with the first tx=0 cycle.
- The requester drops req, or presents a new byte, after seeing gnt. req sampled in the gnt cycle is ignored because state is no longer IDLE.
- Back-to-back: at least one IDLE cycle between stop end and the next start bit. Frame-to-frame period = 160*DIV+1 cycles.
- Changes on req or din during a frame have no effect on the frame in progress.
- Simultaneous requests resolve only by rotating priority; no requester waits more than NREQ-1 frames.
- Reset mid-frame aborts immediately: tx=1, no partial frame is completed, pointer returns to NREQ-1.
- tx, gnt, busy and owner are registered outputs (glitch-free).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - State PARITY is inserted between DATA and STOP.
  - tx = XOR of the 8 latched data bits (even parity) for one bit period.
  - Frame is 11 bits; period = 176*DIV+1 cycles.
- Undefined: no PARITY state; 8N1 framing as above.

Test Plan:
- F=1600000, B=10000 (DIV=10); reset, req=0001, din[7:0]=8'hA5 -> gnt=0001 one cycle. tx sequence is 0,1,0,1,0,0,1,0,1,1, each level held exactly 160 cycles. busy falls on the last stop cycle. owner=0.
- Same params; req=1111 held continuously, each din[i]=i -> grant order 0,1,2,3,0. Consecutive start bits are 1601 cycles apart.
- Pointer=1 after granting requester 1, then req=1001 -> next gnt=1000 (requester 3), then requester 0.
- reset asserted at cycle 700 of a frame -> tx=1 and busy=0 immediately. With req=0010 and reset released, the next start bit comes from requester 1 with a full fresh frame.
- req toggled and din changed to 8'hFF mid-frame -> the in-flight byte is transmitted unchanged; no extra gnt until IDLE.
- UART_TX_PARITY_EN defined, din=8'h07 -> parity bit=1. din=8'h03 -> parity bit=0. Frame = 11 bits × 160 cycles.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Byte-source handshake and serial line bundle for uart_tx_scheduler.
// The master side drives requests/bytes; the slave (scheduler) drives grant, status and tx.
interface uart_tx_scheduler_if #(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned OW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] din;
    logic [NREQ-1:0]   gnt;
    logic [OW-1:0]     owner;
    logic              busy;
    logic              tx;

    modport master (
        output req,
        output din,
        input  gnt,
        input  owner,
        input  busy,
        input  tx
    );

    modport slave (
        input  req,
        input  din,
        output gnt,
        output owner,
        output busy,
        output tx
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART transmitter among NREQ byte sources.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_scheduler #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned B     = 9600,
    parameter int unsigned F     = 50000000,
    parameter int unsigned DIV_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_scheduler_if.slave bus_io
);

    localparam int unsigned DIV = F / (16 * B);
    localparam int unsigned OW  = $clog2(NREQ);
    localparam logic [DIV_W-1:0] TickMax = DIV_W'(DIV - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StStop   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] StParity = 3'd4;
`endif

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("uart_tx_scheduler: NREQ must be in 2..8");
    end
    if (DIV == 0 || $clog2(DIV) > DIV_W) begin : g_bad_div
        $error("uart_tx_scheduler: F/(16*B) must be nonzero and fit in DIV_W bits");
    end

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]       phase_q, phase_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             any_req;
    logic             found;
    logic [OW-1:0]    arb_idx;
    logic [OW-1:0]    sel;
    logic [7:0]       sel_byte;
    logic             tick;
    logic             bit_end;

    // Rotating-priority search starting just after the last granted requester.
    always_comb begin
        any_req  = |bus_io.req;
        found    = 1'b0;
        arb_idx  = '0;
        sel      = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            arb_idx = OW'((int'(ptr_q) + k) % int'(NREQ));
            if (!found && bus_io.req[arb_idx]) begin
                found = 1'b1;
                sel   = arb_idx;
            end
        end
    end

    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (OW'(i) == sel) begin
                sel_byte = bus_io.din[8*i +: 8];
            end
        end
    end

    assign tick    = (tick_cnt_q == TickMax);
    assign bit_end = tick && (phase_q == 4'd15);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        phase_d    = phase_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        gnt_d      = '0;
        tx_d       = tx_q;
        busy_d     = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        if (state_q != StIdle) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + DIV_W'(1);
            phase_d    = tick ? phase_q + 4'd1 : phase_q;
        end

        case (state_q)
            StIdle: begin
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                tick_cnt_d = '0;
                phase_d    = '0;
                if (any_req) begin
                    gnt_d      = NREQ'(1) << sel;
                    owner_d    = sel;
                    ptr_d      = sel;
                    shift_d    = sel_byte;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^sel_byte;
`endif
                    busy_d     = 1'b1;
                    tx_d       = 1'b0;
                    state_d    = StStart;
                end
            end

            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end

            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = parity_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif

            StStop: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            phase_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= OW'(NREQ - 1);
            owner_q    <= '0;
            gnt_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            phase_q    <= phase_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign bus_io.gnt   = gnt_q;
    assign bus_io.owner = owner_q;
    assign bus_io.busy  = busy_q;
    assign bus_io.tx    = tx_q;

endmodule
